// File: rtl/fwd_net_if.sv
// Operand-forwarding network bus: pipeline control, insert/fill ports and
// operand read ports grouped for the fwd_net block.
interface fwd_net_if #(
  parameter int XLEN   = 32,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3
);
  logic                         adv;
  logic                         ins_valid;
  logic [4:0]                   ins_rd;
  logic                         ins_data_vld;
  logic [XLEN-1:0]              ins_data;
  logic                         fill_valid;
  logic [XLEN-1:0]              fill_data;
  logic [NUM_RD*5-1:0]          rd_addr;
  logic [NUM_RD*XLEN-1:0]       rf_data;
  logic [NUM_RD*XLEN-1:0]       real_rd_data;
  logic [NUM_RD-1:0]            fwd_hit;
  logic                         stall;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;
  logic                         fill_err;

  modport master (
    output adv, ins_valid, ins_rd, ins_data_vld, ins_data,
           fill_valid, fill_data, rd_addr, rf_data,
    input  real_rd_data, fwd_hit, stall, occupancy, fill_err
  );

  modport slave (
    input  adv, ins_valid, ins_rd, ins_data_vld, ins_data,
           fill_valid, fill_data, rd_addr, rf_data,
    output real_rd_data, fwd_hit, stall, occupancy, fill_err
  );
endinterface

// File: rtl/fwd_net.sv
// In-flight writer slots with youngest-match operand forwarding, load-return
// fill of the oldest pending slot, and stall on unresolved producers.
module fwd_net #(
  parameter int XLEN   = 32,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3
) (
  input logic     clk,
  input logic     rst,
  fwd_net_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            slot_valid;
  logic [DEPTH-1:0]            slot_dvld;
  logic [DEPTH-1:0][4:0]       slot_rd;
  logic [DEPTH-1:0][XLEN-1:0]  slot_data;

  logic [DEPTH-1:0]            fill_mask;
  logic                        fill_hit;
  logic [DEPTH-1:0]            dvld_post;
  logic [DEPTH-1:0][XLEN-1:0]  data_post;
  logic                        ins_ok;
  logic                        fill_err_q;
  logic [OCC_W-1:0]            occ;

  logic [NUM_RD-1:0]           stall_req;
  logic [NUM_RD-1:0]           hit;
  logic [NUM_RD*XLEN-1:0]      rd_out;

  // Oldest pending slot wins the fill; the mask keeps only the last match.
  always_comb begin
    fill_mask = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (slot_valid[k] && !slot_dvld[k]) begin
        fill_mask    = '0;
        fill_mask[k] = 1'b1;
      end
    end
    fill_hit = |fill_mask;
  end

  always_comb begin
    dvld_post = slot_dvld;
    data_post = slot_data;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (bus.fill_valid && fill_mask[k]) begin
        dvld_post[k] = 1'b1;
        data_post[k] = bus.fill_data;
      end
    end
  end

  always_comb begin
    logic [4:0]      addr;
    logic            found;
    logic            f_dvld;
    logic [XLEN-1:0] f_data;
    stall_req = '0;
    hit       = '0;
    rd_out    = '0;
    addr      = '0;
    found     = 1'b0;
    f_dvld    = 1'b0;
    f_data    = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      addr   = bus.rd_addr[5*p +: 5];
      found  = 1'b0;
      f_dvld = 1'b0;
      f_data = '0;
      // First match scanning from slot 0 is the youngest producer.
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!found && slot_valid[k] && slot_rd[k] == addr) begin
          found  = 1'b1;
          f_dvld = slot_dvld[k];
          f_data = slot_data[k];
        end
      end
      if (addr == 5'd0) begin
        rd_out[XLEN*p +: XLEN] = '0;
      end else if (found && f_dvld) begin
        rd_out[XLEN*p +: XLEN] = f_data;
        hit[p]                 = 1'b1;
      end else begin
        rd_out[XLEN*p +: XLEN] = bus.rf_data[XLEN*p +: XLEN];
        stall_req[p]           = found;
      end
    end
  end

  assign ins_ok = bus.ins_valid && (bus.ins_rd != 5'd0) && !bus.stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
      slot_dvld  <= '0;
      slot_rd    <= '0;
      slot_data  <= '0;
      fill_err_q <= 1'b0;
    end else begin
      fill_err_q <= bus.fill_valid && !fill_hit;
      if (bus.adv) begin
        // Fill-updated contents shift along, so a fill into the oldest
        // slot is simply dropped with it.
        for (int unsigned k = 1; k < DEPTH; k++) begin
          slot_valid[k] <= slot_valid[k-1];
          slot_rd[k]    <= slot_rd[k-1];
          slot_dvld[k]  <= dvld_post[k-1];
          slot_data[k]  <= data_post[k-1];
        end
        slot_valid[0] <= ins_ok;
        slot_rd[0]    <= bus.ins_rd;
        slot_dvld[0]  <= bus.ins_data_vld;
        slot_data[0]  <= bus.ins_data;
      end else begin
        slot_dvld <= dvld_post;
        slot_data <= data_post;
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(slot_valid[k]);
    end
  end

  assign bus.real_rd_data = rd_out;
  assign bus.fwd_hit      = hit;
  assign bus.stall        = |stall_req;
  assign bus.occupancy    = occ;
  assign bus.fill_err     = fill_err_q;
endmodule

// File: tb/tb_fwd_net.sv
// Self-checking bench for fwd_net: directed vector table followed by random
// traffic compared against a queue-based reference model.
module tb_fwd_net;
  localparam int XLEN   = 32;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 3;
  localparam logic [31:0] RF0 = 32'hAAAA_0000;
  localparam logic [31:0] RF1 = 32'hBBBB_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fwd_net_if #(.XLEN(XLEN), .NUM_RD(NUM_RD), .DEPTH(DEPTH)) bus ();

  fwd_net #(.XLEN(XLEN), .NUM_RD(NUM_RD), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          rst, adv, iv;
    logic [4:0]  ird;
    bit          idv;
    logic [31:0] idata;
    bit          fv;
    logic [31:0] fdata;
    logic [4:0]  a0, a1;
    logic [31:0] rf0, rf1;
    logic [31:0] e0, e1;
    logic [1:0]  ehit;
    bit          estall;
    logic [1:0]  eocc;
    bit          eferr;
  } vec_t;

  typedef struct {
    bit          v;
    logic [4:0]  rd;
    bit          dv;
    logic [31:0] d;
  } ent_t;

  vec_t vt[$];
  ent_t mq[$];
  bit   m_ferr;

  function automatic vec_t mk(bit r, bit adv, bit iv, logic [4:0] ird, bit idv,
                              logic [31:0] idata, bit fv, logic [31:0] fdata,
                              logic [4:0] a0, logic [4:0] a1,
                              logic [31:0] rf0, logic [31:0] rf1,
                              logic [31:0] e0, logic [31:0] e1, logic [1:0] ehit,
                              bit estall, logic [1:0] eocc, bit eferr);
    vec_t v;
    v.rst = r; v.adv = adv; v.iv = iv; v.ird = ird; v.idv = idv; v.idata = idata;
    v.fv = fv; v.fdata = fdata; v.a0 = a0; v.a1 = a1; v.rf0 = rf0; v.rf1 = rf1;
    v.e0 = e0; v.e1 = e1; v.ehit = ehit; v.estall = estall; v.eocc = eocc; v.eferr = eferr;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(bit r, bit adv, bit iv, logic [4:0] ird, bit idv, logic [31:0] idata,
                       bit fv, logic [31:0] fdata, logic [4:0] a0, logic [4:0] a1,
                       logic [31:0] rf0, logic [31:0] rf1);
    rst              = r;
    bus.adv          = adv;
    bus.ins_valid    = iv;
    bus.ins_rd       = ird;
    bus.ins_data_vld = idv;
    bus.ins_data     = idata;
    bus.fill_valid   = fv;
    bus.fill_data    = fdata;
    bus.rd_addr      = {a1, a0};
    bus.rf_data      = {rf1, rf0};
  endtask

  task automatic model_reset();
    ent_t e;
    e.v = 1'b0; e.rd = '0; e.dv = 1'b0; e.d = '0;
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back(e);
    m_ferr = 1'b0;
  endtask

  // Reference read: youngest valid producer of the register decides.
  task automatic model_read(input logic [4:0] a, input logic [31:0] rf,
                            output logic [31:0] val, output bit h, output bit s);
    val = rf; h = 1'b0; s = 1'b0;
    if (a == 5'd0) begin
      val = '0;
      return;
    end
    foreach (mq[i]) begin
      if (mq[i].v && mq[i].rd == a) begin
        if (mq[i].dv) begin val = mq[i].d; h = 1'b1; end
        else s = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    logic [4:0]  a[NUM_RD];
    logic [31:0] rf[NUM_RD];
    logic [31:0] ev[NUM_RD];
    bit          eh[NUM_RD];
    bit          es[NUM_RD];
    bit          m_stall;
    int          m_occ;
    bit          r_rst, r_adv, r_iv, r_idv, r_fv, found;
    logic [4:0]  r_ird;
    logic [31:0] r_idata, r_fdata;
    ent_t        ne;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RF0, RF1);
    repeat (2) @(posedge clk);
    #1;

    vt.push_back(mk(0,0,0, 0,0,32'h0,  0,32'h0,  3, 0, RF0,ONES, RF0,32'h0,   2'b00,0,2'd0,0));
    vt.push_back(mk(0,1,1, 5,1,32'h11, 0,32'h0,  5, 0, RF0,32'h0, RF0,32'h0,  2'b00,0,2'd0,0));
    vt.push_back(mk(0,0,0, 0,0,32'h0,  0,32'h0,  5, 5, RF0,RF1, 32'h11,32'h11, 2'b11,0,2'd1,0));
    vt.push_back(mk(0,1,1, 5,1,32'hA,  0,32'h0,  5, 0, RF0,RF1, 32'h11,32'h0,  2'b01,0,2'd1,0));
    vt.push_back(mk(0,1,1, 5,1,32'hB,  0,32'h0,  5, 9, RF0,RF1, 32'hA,RF1,     2'b01,0,2'd2,0));
    vt.push_back(mk(0,1,0, 0,0,32'h0,  0,32'h0,  5, 5, RF0,RF1, 32'hB,32'hB,   2'b11,0,2'd3,0));
    vt.push_back(mk(0,1,0, 0,0,32'h0,  0,32'h0,  5, 0, RF0,RF1, 32'hB,32'h0,   2'b01,0,2'd2,0));
    vt.push_back(mk(0,1,0, 0,0,32'h0,  0,32'h0,  5, 0, RF0,RF1, 32'hB,32'h0,   2'b01,0,2'd1,0));
    vt.push_back(mk(0,0,1, 6,1,32'h66, 0,32'h0,  5, 0, RF0,RF1, RF0,32'h0,     2'b00,0,2'd0,0));
    vt.push_back(mk(0,0,0, 0,0,32'h0,  1,32'h77, 0, 6, RF0,RF1, 32'h0,RF1,     2'b00,0,2'd0,0));
    vt.push_back(mk(0,0,0, 0,0,32'h0,  0,32'h0,  3, 6, RF0,RF1, RF0,RF1,       2'b00,0,2'd0,1));
    vt.push_back(mk(0,1,1, 7,0,32'hDEAD,0,32'h0, 7, 0, RF0,RF1, RF0,32'h0,     2'b00,0,2'd0,0));
    vt.push_back(mk(0,1,1, 8,1,32'h88, 0,32'h0,  7, 8, RF0,RF1, RF0,RF1,       2'b00,1,2'd1,0));
    vt.push_back(mk(0,1,1, 8,1,32'h88, 1,32'h99, 7, 8, RF0,RF1, RF0,RF1,       2'b00,1,2'd1,0));
    vt.push_back(mk(0,0,0, 0,0,32'h0,  0,32'h0,  7, 8, RF0,RF1, 32'h99,RF1,    2'b01,0,2'd1,0));
    vt.push_back(mk(0,1,1, 3,1,32'h33, 0,32'h0,  7, 0, RF0,RF1, 32'h99,32'h0,  2'b01,0,2'd1,0));
    vt.push_back(mk(0,1,1, 0,1,32'h55, 0,32'h0,  0, 3, ONES,RF1, 32'h0,32'h33, 2'b10,0,2'd1,0));
    vt.push_back(mk(0,0,0, 0,0,32'h0,  0,32'h0,  3, 0, RF0,ONES, 32'h33,32'h0, 2'b01,0,2'd1,0));
    vt.push_back(mk(0,1,1,10,0,32'h0,  0,32'h0,  0, 0, RF0,RF1, 32'h0,32'h0,   2'b00,0,2'd1,0));
    vt.push_back(mk(0,1,1,11,1,32'hB1, 0,32'h0,  0, 0, RF0,RF1, 32'h0,32'h0,   2'b00,0,2'd2,0));
    vt.push_back(mk(0,1,1,12,1,32'hC1, 0,32'h0,  0, 0, RF0,RF1, 32'h0,32'h0,   2'b00,0,2'd2,0));
    vt.push_back(mk(1,1,1,13,1,32'hD1, 1,32'hEE, 10,11, RF0,RF1, RF0,32'hB1,   2'b10,1,2'd3,0));
    vt.push_back(mk(0,0,0, 0,0,32'h0,  0,32'h0,  10,12, RF0,RF1, RF0,RF1,      2'b00,0,2'd0,0));
    vt.push_back(mk(0,0,0, 0,0,32'h0,  0,32'h0,  11, 0, RF0,RF1, RF0,32'h0,    2'b00,0,2'd0,0));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].adv, vt[i].iv, vt[i].ird, vt[i].idv, vt[i].idata,
            vt[i].fv, vt[i].fdata, vt[i].a0, vt[i].a1, vt[i].rf0, vt[i].rf1);
      #2;
      chk($sformatf("vec%0d rd0", i),    64'(bus.real_rd_data[31:0]),  64'(vt[i].e0));
      chk($sformatf("vec%0d rd1", i),    64'(bus.real_rd_data[63:32]), 64'(vt[i].e1));
      chk($sformatf("vec%0d hit", i),    64'(bus.fwd_hit),   64'(vt[i].ehit));
      chk($sformatf("vec%0d stall", i),  64'(bus.stall),     64'(vt[i].estall));
      chk($sformatf("vec%0d occ", i),    64'(bus.occupancy), 64'(vt[i].eocc));
      chk($sformatf("vec%0d ferr", i),   64'(bus.fill_err),  64'(vt[i].eferr));
      @(posedge clk);
      #1;
    end

    // Random traffic against the queue model, starting from a fresh reset.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RF0, RF1);
    @(posedge clk);
    #1;
    model_reset();

    for (int cyc = 0; cyc < 600; cyc++) begin
      r_rst   = ($urandom_range(0, 99) == 0);
      r_adv   = ($urandom_range(0, 3) != 0);
      r_iv    = ($urandom_range(0, 9) < 6);
      r_ird   = 5'($urandom_range(0, 7));
      r_idv   = ($urandom_range(0, 9) < 6);
      r_idata = $urandom;
      r_fv    = ($urandom_range(0, 9) < 2);
      r_fdata = $urandom;
      for (int p = 0; p < NUM_RD; p++) begin
        a[p]  = 5'($urandom_range(0, 7));
        rf[p] = $urandom;
      end
      drive(r_rst, r_adv, r_iv, r_ird, r_idv, r_idata, r_fv, r_fdata, a[0], a[1], rf[0], rf[1]);
      #2;

      m_stall = 1'b0;
      m_occ   = 0;
      foreach (mq[i]) if (mq[i].v) m_occ++;
      for (int p = 0; p < NUM_RD; p++) begin
        model_read(a[p], rf[p], ev[p], eh[p], es[p]);
        m_stall |= es[p];
        chk($sformatf("rnd%0d rd%0d", cyc, p), 64'(bus.real_rd_data[XLEN*p +: XLEN]), 64'(ev[p]));
        chk($sformatf("rnd%0d hit%0d", cyc, p), 64'(bus.fwd_hit[p]), 64'(eh[p]));
      end
      chk($sformatf("rnd%0d stall", cyc), 64'(bus.stall),     64'(m_stall));
      chk($sformatf("rnd%0d occ", cyc),   64'(bus.occupancy), 64'(m_occ));
      chk($sformatf("rnd%0d ferr", cyc),  64'(bus.fill_err),  64'(m_ferr));

      if (r_rst) begin
        model_reset();
      end else begin
        found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (!found && mq[i].v && !mq[i].dv) begin
            found = 1'b1;
            if (r_fv) begin mq[i].dv = 1'b1; mq[i].d = r_fdata; end
          end
        end
        m_ferr = r_fv && !found;
        if (r_adv) begin
          ne.v  = r_iv && (r_ird != 5'd0) && !m_stall;
          ne.rd = r_ird;
          ne.dv = r_idv;
          ne.d  = r_idata;
          mq.push_front(ne);
          void'(mq.pop_back());
        end
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fwd_net.md
FWD_NET -- requirements
Module: fwd_net

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data width.
REQ-002 Parameter NUM_RD, default 2, SHALL set the number of operand read ports.
REQ-003 Parameter DEPTH, default 3, SHALL set the number of in-flight write slots (legal range 1..8).
REQ-004 Ports SHALL be:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- adv  in  1  pipeline advance; 0 freezes all slots.
- ins_valid  in  1  new writer entering slot 0.
- ins_rd  in  5  destination register of the new writer.
- ins_data_vld  in  1  result known at insert; 0 for loads.
- ins_data  in  XLEN  result at insert.
- fill_valid  in  1  late result (load return).
- fill_data  in  XLEN  late result value.
- rd_addr  in  NUM_RD*5  per-port source register; port p at bits [5p+4:5p].
- rf_data  in  NUM_RD*XLEN  per-port register-file read data.
- real_rd_data  out  NUM_RD*XLEN  per-port forwarded operand.
- fwd_hit  out  NUM_RD  per-port "operand came from a slot".
- stall  out  1  an operand's producer has no data yet.
- occupancy  out  $clog2(DEPTH+1)  count of valid slots.
- fill_err  out  1  registered one-cycle pulse: fill with no pending entry.

Function
REQ-005 Each slot SHALL hold {valid, rd, data_vld, data}; slot 0 is youngest, slot DEPTH-1 oldest.
REQ-006 On a clock edge with adv=1, every slot k SHALL move to k+1, slot DEPTH-1 SHALL be discarded, and slot 0 SHALL load the insert entry.
REQ-007 The insert entry SHALL be valid only if ins_valid=1, ins_rd!=0 and stall=0; when stall=1 a bubble (valid=0) SHALL be inserted regardless of ins_valid.
REQ-008 With adv=0, slots SHALL hold their values; inserts SHALL be ignored; fills SHALL still apply.
REQ-009 fill_valid=1 SHALL write fill_data and set data_vld=1 in the oldest slot with valid=1 and data_vld=0; with adv=1 the update SHALL travel with the entry into its shifted position, including the oldest slot's discard.
REQ-010 A fill with no such slot SHALL change no state and SHALL assert fill_err for exactly the next cycle.
REQ-011 Per port p, combinationally: if rd_addr=0, real_rd_data=0 and fwd_hit=0.
REQ-012 Otherwise the youngest valid slot whose rd matches SHALL be selected; if its data_vld=1, real_rd_data=slot data and fwd_hit=1.
REQ-013 If the selected slot has data_vld=0, port p SHALL request a stall, real_rd_data=rf_data and fwd_hit=0; older matching slots SHALL NOT be used.
REQ-014 With no matching slot, real_rd_data=rf_data and fwd_hit=0.
REQ-015 stall SHALL be the OR of all port requests.
REQ-016 A fill SHALL become visible to reads on the cycle after the fill edge (no same-cycle bypass).
REQ-017 occupancy SHALL equal the number of valid slots after each edge.

Reset
REQ-018 rst=1 at an edge SHALL clear every slot's valid and data_vld and clear fill_err; rst SHALL override adv, ins_valid and fill_valid in that cycle.
REQ-019 After reset: occupancy=0, stall=0, fill_err=0, fwd_hit=0, and each real_rd_data equals rf_data (0 for rd_addr=0).

Verification
REQ-020 Bench SHALL cover:
- Insert rd=5, data=0x11 with data_vld=1, adv=1; next cycle rd_addr[0]=5 -> real_rd_data=0x11, fwd_hit[0]=1, stall=0.
- Insert rd=5 data 0xA, then rd=5 data 0xB on consecutive adv cycles; read 5 -> 0xB (youngest wins); after DEPTH further adv with no inserts -> rf_data, fwd_hit=0.
- Insert load rd=7 (data_vld=0); read 7 -> stall=1 and bubble inserted while stalled; fill 0x99 -> stall still 1 that cycle, 0 next cycle with output 0x99.
- ins_rd=0 with ins_valid=1 -> occupancy unchanged; rd_addr=0 -> output 0 even if rf_data=0xFFFF_FFFF.
- fill_valid with no pending load -> fill_err high exactly one cycle, slots unchanged.
- rst asserted with full slots and fill_valid=1 -> next cycle occupancy=0, stall=0, all outputs pass rf_data.
